// File: rtl/motor_ramp_sequencer_if.sv
// Command/duty bundle between line-following logic, the ramp sequencer and the motor PWM block.
interface motor_ramp_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir1;
    logic [7:0] cmd_speed1;
    logic [1:0] cmd_dir2;
    logic [7:0] cmd_speed2;
    logic [7:0] duty_cycle1_fwd;
    logic [7:0] duty_cycle1_back;
    logic [7:0] duty_cycle2_fwd;
    logic [7:0] duty_cycle2_back;
    logic       busy;
    logic       wdog_trip;

    modport master (
        output cmd_valid, cmd_dir1, cmd_speed1, cmd_dir2, cmd_speed2,
        input  cmd_ready, duty_cycle1_fwd, duty_cycle1_back,
        input  duty_cycle2_fwd, duty_cycle2_back, busy, wdog_trip
    );

    modport slave (
        input  cmd_valid, cmd_dir1, cmd_speed1, cmd_dir2, cmd_speed2,
        output cmd_ready, duty_cycle1_fwd, duty_cycle1_back,
        output duty_cycle2_fwd, duty_cycle2_back, busy, wdog_trip
    );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// Two-channel duty ramp with drain + dead-time on direction reversal.
// Optional command watchdog enabled by defining MOTOR_WDOG_EN.
module motor_ramp_sequencer #(
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned DEAD_CYCLES = 500000,
    parameter int unsigned WDOG_CYCLES = 25000000
) (
    input  logic                   clk_50,
    input  logic                   rst_n,
    motor_ramp_sequencer_if.slave  bus
);
    localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [8:0]        STEP9     = 9'(RAMP_STEP);
    localparam logic [7:0]        STEP8     = 8'(RAMP_STEP);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b01;
    localparam logic [1:0] DIR_BACK = 2'b10;

    logic [DIV_W-1:0]       pre_q, pre_d;
    logic                   tick_c;
    logic                   accept_c;
    logic                   wdog_fire_c;
    logic [1:0][1:0]        state_q, state_d;
    logic [1:0][1:0]        cur_dir_q, cur_dir_d;
    logic [1:0][1:0]        tgt_dir_q, tgt_dir_d;
    logic [1:0][7:0]        tgt_spd_q, tgt_spd_d;
    logic [1:0][7:0]        duty_q, duty_d;
    logic [1:0][DEAD_W-1:0] dead_q, dead_d;
    logic [1:0][7:0]        fwd_q, fwd_d;
    logic [1:0][7:0]        back_q, back_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   wdog_trip_q, wdog_trip_d;

    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == DIR_FWD || d == DIR_BACK) ? d : DIR_STOP;
    endfunction

    // Step toward tgt; 9-bit sum so an 8-bit overflow is caught and clamped at tgt.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, cur} + STEP9;
        res = cur;
        if (cur < tgt) begin
            res = (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        end else if (cur > tgt) begin
            res = ({1'b0, 8'(cur - tgt)} <= STEP9) ? tgt : 8'(cur - STEP8);
        end
        return res;
    endfunction

    function automatic logic [7:0] ramp_down(input logic [7:0] cur);
        return ({1'b0, cur} <= STEP9) ? 8'd0 : 8'(cur - STEP8);
    endfunction

    assign accept_c = bus.cmd_valid & cmd_ready_q;
    assign tick_c   = (pre_q == DIV_LAST);

    // Shared prescaler and command targets.
    always_comb begin
        pre_d     = tick_c ? '0 : pre_q + DIV_W'(1);
        tgt_dir_d = tgt_dir_q;
        tgt_spd_d = tgt_spd_q;
        if (accept_c) begin
            tgt_dir_d[0] = norm_dir(bus.cmd_dir1);
            tgt_spd_d[0] = (norm_dir(bus.cmd_dir1) == DIR_STOP) ? 8'd0 : bus.cmd_speed1;
            tgt_dir_d[1] = norm_dir(bus.cmd_dir2);
            tgt_spd_d[1] = (norm_dir(bus.cmd_dir2) == DIR_STOP) ? 8'd0 : bus.cmd_speed2;
        end else if (wdog_fire_c) begin
            tgt_dir_d = {DIR_STOP, DIR_STOP};
            tgt_spd_d = '0;
        end
    end

    // Per-channel ramp FSM and output mapping.
    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        duty_d      = duty_q;
        dead_d      = dead_q;
        fwd_d       = '0;
        back_d      = '0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
            case (state_q[ch])
                ST_STOP: begin
                    duty_d[ch]    = 8'd0;
                    cur_dir_d[ch] = DIR_STOP;
                    if (tgt_dir_q[ch] != DIR_STOP && tgt_spd_q[ch] != 8'd0) begin
                        cur_dir_d[ch] = tgt_dir_q[ch];
                        state_d[ch]   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tgt_dir_q[ch] != DIR_STOP && tgt_dir_q[ch] != cur_dir_q[ch]) begin
                        state_d[ch] = ST_DRAIN;
                    end else begin
                        if (tick_c) duty_d[ch] = ramp_toward(duty_q[ch], tgt_spd_q[ch]);
                        if (tgt_dir_q[ch] == DIR_STOP && duty_d[ch] == 8'd0) begin
                            state_d[ch]   = ST_STOP;
                            cur_dir_d[ch] = DIR_STOP;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tgt_dir_q[ch] == cur_dir_q[ch]) begin
                        state_d[ch] = ST_RUN;
                    end else if (duty_q[ch] == 8'd0) begin
                        state_d[ch] = ST_DEAD;
                        dead_d[ch]  = DEAD_LOAD;
                    end else if (tick_c) begin
                        duty_d[ch] = ramp_down(duty_q[ch]);
                        if (duty_d[ch] == 8'd0) begin
                            state_d[ch] = ST_DEAD;
                            dead_d[ch]  = DEAD_LOAD;
                        end
                    end
                end
                default: begin
                    duty_d[ch] = 8'd0;
                    if (dead_q[ch] == '0) begin
                        cur_dir_d[ch] = tgt_dir_q[ch];
                        state_d[ch]   = (tgt_dir_q[ch] == DIR_STOP) ? ST_STOP : ST_RUN;
                    end else begin
                        dead_d[ch] = dead_q[ch] - DEAD_W'(1);
                    end
                end
            endcase
            fwd_d[ch]  = (cur_dir_q[ch] == DIR_FWD)  ? duty_q[ch] : 8'd0;
            back_d[ch] = (cur_dir_q[ch] == DIR_BACK) ? duty_q[ch] : 8'd0;
            if (state_d[ch] == ST_DRAIN || state_d[ch] == ST_DEAD) busy_d = 1'b1;
            if (state_d[ch] == ST_DEAD) cmd_ready_d = 1'b0;
        end
    end

`ifdef MOTOR_WDOG_EN
    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counter saturates at the limit so targets stay forced to stop until a new command.
    always_comb begin
        wdog_fire_c = (wd_q == WD_LAST);
        wdog_trip_d = wdog_trip_q | wdog_fire_c;
        if (accept_c)         wd_d = '0;
        else if (wdog_fire_c) wd_d = wd_q;
        else                  wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign wdog_fire_c = 1'b0;
    assign wdog_trip_d = 1'b0;
`endif

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            pre_q       <= '0;
            state_q     <= {ST_STOP, ST_STOP};
            cur_dir_q   <= {DIR_STOP, DIR_STOP};
            tgt_dir_q   <= {DIR_STOP, DIR_STOP};
            tgt_spd_q   <= '0;
            duty_q      <= '0;
            dead_q      <= '0;
            fwd_q       <= '0;
            back_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wdog_trip_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            tgt_dir_q   <= tgt_dir_d;
            tgt_spd_q   <= tgt_spd_d;
            duty_q      <= duty_d;
            dead_q      <= dead_d;
            fwd_q       <= fwd_d;
            back_q      <= back_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign bus.cmd_ready        = cmd_ready_q;
    assign bus.duty_cycle1_fwd  = fwd_q[0];
    assign bus.duty_cycle1_back = back_q[0];
    assign bus.duty_cycle2_fwd  = fwd_q[1];
    assign bus.duty_cycle2_back = back_q[1];
    assign bus.busy             = busy_q;
    assign bus.wdog_trip        = wdog_trip_q;
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: ramp, saturation, reversal, drain abort, reset, watchdog.
module tb_motor_ramp_sequencer;
    localparam int unsigned RAMP_DIV    = 4;
    localparam int unsigned RAMP_STEP   = 16;
    localparam int unsigned DEAD_CYCLES = 10;
    localparam int unsigned WDOG_CYCLES = 200;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_50 = ~clk_50;

    motor_ramp_sequencer_if bus ();

    motor_ramp_sequencer #(
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int ovl    = 0;
    int f1_v[$], f1_t[$], b1_v[$], b1_t[$];
    int n_rdy_lo, n_busy_rdy_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and watch the fwd/back exclusivity invariant.
    task automatic cyc();
        @(negedge clk_50);
        if (bus.duty_cycle1_fwd != 8'd0 && bus.duty_cycle1_back != 8'd0) ovl++;
        if (bus.duty_cycle2_fwd != 8'd0 && bus.duty_cycle2_back != 8'd0) ovl++;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] d1, input logic [7:0] s1,
                        input logic [1:0] d2, input logic [7:0] s2);
        int n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir1   = d1;
        bus.cmd_speed1 = s1;
        bus.cmd_dir2   = d2;
        bus.cmd_speed2 = s2;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("send_ready_in_time", 32'(n < 50), 1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_fwd1(input string tag, input logic [7:0] v, input int budget);
        int n = 0;
        while (bus.duty_cycle1_fwd !== v && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(bus.duty_cycle1_fwd), 32'(v));
    endtask

    // Record every change of channel-1 outputs plus cmd_ready/busy activity over ncyc cycles.
    task automatic trace(input int ncyc);
        logic [7:0] pf, pb;
        f1_v.delete(); f1_t.delete(); b1_v.delete(); b1_t.delete();
        n_rdy_lo      = 0;
        n_busy_rdy_lo = 0;
        pf = bus.duty_cycle1_fwd;
        pb = bus.duty_cycle1_back;
        for (int i = 1; i <= ncyc; i++) begin
            cyc();
            if (bus.duty_cycle1_fwd != pf) begin f1_v.push_back(int'(bus.duty_cycle1_fwd)); f1_t.push_back(i); end
            if (bus.duty_cycle1_back != pb) begin b1_v.push_back(int'(bus.duty_cycle1_back)); b1_t.push_back(i); end
            if (bus.cmd_ready == 1'b0) begin
                n_rdy_lo++;
                if (bus.busy == 1'b1) n_busy_rdy_lo++;
            end
            pf = bus.duty_cycle1_fwd;
            pb = bus.duty_cycle1_back;
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_dir1   = 2'b00;
        bus.cmd_speed1 = 8'd0;
        bus.cmd_dir2   = 2'b00;
        bus.cmd_speed2 = 8'd0;

        // Reset state
        do_reset();
        chk("rst_fwd1", 32'(bus.duty_cycle1_fwd), 0);
        chk("rst_back1", 32'(bus.duty_cycle1_back), 0);
        chk("rst_fwd2", 32'(bus.duty_cycle2_fwd), 0);
        chk("rst_back2", 32'(bus.duty_cycle2_back), 0);
        chk("rst_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wdog", 32'(bus.wdog_trip), 0);

        // Basic ramp: 16,32,48,64 one tick (4 cycles) apart, then hold
        send(2'b01, 8'd64, 2'b00, 8'd200);
        trace(30);
        chk("ramp_nchg", 32'(f1_v.size()), 4);
        for (int k = 0; k < 4 && k < f1_v.size(); k++) chk("ramp_val", 32'(f1_v[k]), 32'(16 * (k + 1)));
        for (int k = 1; k < 4 && k < f1_t.size(); k++) chk("ramp_gap", 32'(f1_t[k] - f1_t[k-1]), 4);
        chk("ramp_hold", 32'(bus.duty_cycle1_fwd), 64);
        chk("ramp_back1", 32'(b1_v.size()), 0);
        chk("ramp_fwd2", 32'(bus.duty_cycle2_fwd), 0);
        chk("ramp_back2", 32'(bus.duty_cycle2_back), 0);
        chk("ramp_busy", 32'(bus.busy), 0);

        // Saturation: 16..192 then exactly 200
        do_reset();
        send(2'b01, 8'd200, 2'b00, 8'd0);
        trace(70);
        chk("sat_nchg", 32'(f1_v.size()), 13);
        if (f1_v.size() == 13) begin
            chk("sat_192", 32'(f1_v[11]), 192);
            chk("sat_200", 32'(f1_v[12]), 200);
        end
        chk("sat_final", 32'(bus.duty_cycle1_fwd), 200);

        // Reversal with dead-time; channel 2 runs back concurrently
        do_reset();
        send(2'b01, 8'd64, 2'b10, 8'd48);
        wait_fwd1("rev_pre64", 8'd64, 40);
        chk("rev_ch2_back", 32'(bus.duty_cycle2_back), 48);
        ovl = 0;
        send(2'b10, 8'd32, 2'b10, 8'd48);
        trace(70);
        chk("rev_fwd_nchg", 32'(f1_v.size()), 4);
        for (int k = 0; k < 4 && k < f1_v.size(); k++) chk("rev_fwd_val", 32'(f1_v[k]), 32'(48 - 16 * k));
        chk("rev_back_nchg", 32'(b1_v.size()), 2);
        for (int k = 0; k < 2 && k < b1_v.size(); k++) chk("rev_back_val", 32'(b1_v[k]), 32'(16 * (k + 1)));
        chk("rev_ready_lo", 32'(n_rdy_lo), 10);
        chk("rev_busy_dead", 32'(n_busy_rdy_lo), 10);
        if (f1_t.size() == 4 && b1_t.size() >= 1) chk("rev_gap", 32'(b1_t[0] - f1_t[3] > 10), 1);
        chk("rev_no_overlap", 32'(ovl), 0);
        chk("rev_busy_end", 32'(bus.busy), 0);

        // Abort during drain: no dead phase, back up to 64
        do_reset();
        send(2'b01, 8'd64, 2'b00, 8'd0);
        wait_fwd1("abort_pre64", 8'd64, 40);
        send(2'b10, 8'd64, 2'b00, 8'd0);
        wait_fwd1("abort_at32", 8'd32, 20);
        chk("abort_busy_drain", 32'(bus.busy), 1);
        send(2'b01, 8'd64, 2'b00, 8'd0);
        trace(30);
        chk("abort_ready_lo", 32'(n_rdy_lo), 0);
        chk("abort_nchg", 32'(f1_v.size()), 2);
        if (f1_v.size() == 2) begin
            chk("abort_48", 32'(f1_v[0]), 48);
            chk("abort_64", 32'(f1_v[1]), 64);
        end
        chk("abort_back1", 32'(b1_v.size()), 0);
        chk("abort_busy_end", 32'(bus.busy), 0);

        // Reset in the middle of dead-time
        do_reset();
        send(2'b01, 8'd64, 2'b00, 8'd0);
        wait_fwd1("mid_pre64", 8'd64, 40);
        send(2'b10, 8'd64, 2'b00, 8'd0);
        begin
            int n = 0;
            while (bus.cmd_ready !== 1'b0 && n < 40) begin
                cyc();
                n++;
            end
            chk("mid_dead_reached", 32'(bus.cmd_ready), 0);
        end
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_rst_fwd1", 32'(bus.duty_cycle1_fwd), 0);
        chk("mid_rst_back1", 32'(bus.duty_cycle1_back), 0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 1);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        trace(20);
        chk("mid_rst_quiet", 32'(f1_v.size() + b1_v.size()), 0);

`ifdef MOTOR_WDOG_EN
        // Watchdog: trips exactly WDOG_CYCLES after the last accepted command
        do_reset();
        send(2'b01, 8'd64, 2'b00, 8'd0);
        repeat (WDOG_CYCLES - 1) cyc();
        chk("wdog_not_yet", 32'(bus.wdog_trip), 0);
        chk("wdog_run64", 32'(bus.duty_cycle1_fwd), 64);
        cyc();
        chk("wdog_trip", 32'(bus.wdog_trip), 1);
        trace(40);
        chk("wdog_down_nchg", 32'(f1_v.size()), 4);
        chk("wdog_down_0", 32'(bus.duty_cycle1_fwd), 0);
        send(2'b01, 8'd64, 2'b00, 8'd0);
        wait_fwd1("wdog_cmd_honoured", 8'd64, 40);
        chk("wdog_sticky", 32'(bus.wdog_trip), 1);
        do_reset();
        chk("wdog_rst_clear", 32'(bus.wdog_trip), 0);
`else
        // Without the watchdog a long idle period changes nothing
        do_reset();
        send(2'b01, 8'd64, 2'b00, 8'd0);
        repeat (250) cyc();
        chk("nowdog_hold", 32'(bus.duty_cycle1_fwd), 64);
        chk("nowdog_trip", 32'(bus.wdog_trip), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
